mult_req_scheduler: RTL and testbench

//  Shares one fixed-latency pipelined multiplier among NUM_REQ requesters in the AFU.
//  - Round-robin arbitration over valid/ready request ports.
//  - Tags each issued operation with its requester id and carries the tag alongside the multiplier pipeline.
//  - Returns {id, product} through a response FIFO with valid/ready.
//  - Credit-limited issue, so the FIFO never overflows.

---
 rtl/mult_sched_pkg.sv | 23 ++
 rtl/mult_sched_rsp_fifo.sv | 57 +++++
 rtl/mult_req_scheduler.sv | 125 ++++++++++++
 tb/tb_mult_req_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and sizing for the multiplier request scheduler.
package mult_sched_pkg;

    localparam int unsigned NUM_REQ     = 4;
    localparam int unsigned DATA_LEN    = 32;
    localparam int unsigned MUL_LATENCY = 3;
    localparam int unsigned FIFO_DEPTH  = 8;
    localparam int unsigned ID_W        = $clog2(NUM_REQ);

    typedef logic [ID_W-1:0]     t_req_id;
    typedef logic [DATA_LEN-1:0] t_operand;

    typedef struct packed {
        logic    valid;
        t_req_id id;
    } t_tag;

    typedef struct packed {
        t_req_id  id;
        t_operand result;
    } t_rsp;

endpackage

// File: rtl/mult_sched_rsp_fifo.sv
// Response FIFO: storage array plus a registered head, so a pushed entry reaches
// the output one cycle after it lands in storage.
module mult_sched_rsp_fifo
    import mult_sched_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic clk2,
    input  logic reset,
    input  logic push,
    input  t_rsp push_data,
    input  logic pop,
    output logic full_c,
    output logic out_valid,
    output t_rsp out_data
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    t_rsp             mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] mem_cnt;
    logic             load;

    // Refill the head whenever it is empty or being popped this cycle.
    assign load   = (mem_cnt != '0) && (!out_valid || pop);
    assign full_c = (mem_cnt + CNT_W'(out_valid)) == CNT_W'(DEPTH);

    always_ff @(posedge clk2) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk2) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                out_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
            end
            mem_cnt   <= mem_cnt + CNT_W'(push) - CNT_W'(load);
            out_valid <= load || (out_valid && !pop);
        end
    end

endmodule

// File: rtl/mult_req_scheduler.sv
// Round-robin sharing of one pipelined multiplier among NUM_REQ requesters,
// with id tags riding alongside the multiplier and credit-limited issue.
module mult_req_scheduler
    import mult_sched_pkg::*;
(
    input  logic                        clk2,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_LEN-1:0] req_a,
    input  logic [NUM_REQ*DATA_LEN-1:0] req_b,
    output logic                        mul_reset,
    output logic [DATA_LEN-1:0]         mul_a,
    output logic [DATA_LEN-1:0]         mul_b,
    input  logic [DATA_LEN-1:0]         mul_result,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [DATA_LEN-1:0]         rsp_result,
    output logic                        busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    t_req_id          ptr;
    t_req_id          ptr_nxt;
    t_req_id          grant_id;
    logic             grant_any;
    logic             can_issue;
    logic             pop;
    logic             push;
    logic             fifo_full_c;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [ID_W:0]    idx;
    t_operand         op_a [NUM_REQ];
    t_operand         op_b [NUM_REQ];
    t_tag             tag_pipe [MUL_LATENCY];
    t_rsp             push_data;
    t_rsp             head;

    assign mul_reset = reset;
    assign can_issue = !reset && (outstanding < CNT_W'(FIFO_DEPTH));
    assign pop       = rsp_valid && rsp_ready;
    assign push      = tag_pipe[MUL_LATENCY-1].valid;
    assign push_data = '{id: tag_pipe[MUL_LATENCY-1].id, result: mul_result};
    assign outstanding_nxt = outstanding + CNT_W'(grant_any) - CNT_W'(pop);

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            op_a[k] = req_a[k*DATA_LEN +: DATA_LEN];
            op_b[k] = req_b[k*DATA_LEN +: DATA_LEN];
        end
    end

    // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = '0;
        if (can_issue) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = {1'b0, ptr} + (ID_W+1)'(k);
                if (idx >= (ID_W+1)'(NUM_REQ)) begin
                    idx = idx - (ID_W+1)'(NUM_REQ);
                end
                if (!grant_any && req_valid[idx[ID_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_id  = idx[ID_W-1:0];
                end
            end
        end
        req_ready = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
        ptr_nxt   = (grant_id == t_req_id'(NUM_REQ - 1)) ? '0 : grant_id + t_req_id'(1);
    end

    always_ff @(posedge clk2) begin
        if (reset) begin
            ptr         <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            outstanding <= '0;
            busy        <= 1'b0;
            for (int s = 0; s < MUL_LATENCY; s++) begin
                tag_pipe[s] <= '0;
            end
        end else begin
            if (grant_any) begin
                ptr <= ptr_nxt;
            end
            mul_a       <= grant_any ? op_a[grant_id] : '0;
            mul_b       <= grant_any ? op_b[grant_id] : '0;
            tag_pipe[0] <= '{valid: grant_any, id: grant_id};
            for (int s = 1; s < MUL_LATENCY; s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end
            outstanding <= outstanding_nxt;
            busy        <= (outstanding_nxt != '0);
        end
    end

    // Credits bound the outstanding ops to FIFO_DEPTH, so a push never meets a full FIFO.
    always_ff @(posedge clk2) begin
        if (!reset) begin
            assert (!(push && fifo_full_c)) else $error("response fifo overflow");
        end
    end

    mult_sched_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk2      (clk2),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full_c    (fifo_full_c),
        .out_valid (rsp_valid),
        .out_data  (head)
    );

    assign rsp_id     = head.id;
    assign rsp_result = head.result;

endmodule

// File: tb/tb_mult_req_scheduler.sv
// Bench for mult_req_scheduler: issue-order response model with credit and latency rules.
module tb_mult_req_scheduler;

    logic          clk2;
    logic          reset;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [127:0]  req_a;
    logic [127:0]  req_b;
    logic          mul_reset;
    logic [31:0]   mul_a;
    logic [31:0]   mul_b;
    logic [31:0]   mul_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [31:0]   rsp_result;
    logic          busy;

    mult_req_scheduler dut (
        .clk2       (clk2),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_reset  (mul_reset),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    // Multiplier model: product visible two cycles after mul_a/mul_b
    logic [31:0] p0;
    logic [31:0] p1;
    always @(posedge clk2) begin
        if (mul_reset) begin
            p0 <= '0;
            p1 <= '0;
        end else begin
            p0 <= mul_a * mul_b;
            p1 <= p0;
        end
    end
    assign mul_result = p1;

    typedef struct {
        int          id;
        logic [31:0] res;
        int          issue;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          m_out = 0;
    int          m_ptr = 0;
    int          last_pop = -100;
    int          obs_acc = 0;
    int          acc_base;
    logic [31:0] exp_mul_a = '0;
    logic [31:0] exp_mul_b = '0;
    logic [1:0]  last_id = '0;
    logic [31:0] last_res = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        int idx;
        if (m_out >= 8) return -1;
        for (int k = 0; k < 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    // One clock: check outputs at negedge against the model, then advance the model.
    task automatic cycle();
        int          g;
        logic        ev;
        logic        pop;
        logic [31:0] ga;
        logic [31:0] gb;
        @(negedge clk2);
        g = model_grant();
        check("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        check("mul_a", 64'(mul_a), 64'(exp_mul_a));
        check("mul_b", 64'(mul_b), 64'(exp_mul_b));
        check("busy", 64'(busy), 64'(m_out != 0));
        ev = (q.size() != 0) && (cyc >= q[0].issue + 5) && (cyc >= last_pop + 1);
        check("rsp_valid", 64'(rsp_valid), 64'(ev));
        if (ev) begin
            check("rsp_id", 64'(rsp_id), 64'(q[0].id));
            check("rsp_result", 64'(rsp_result), 64'(q[0].res));
        end
        if (req_ready != 4'b0) obs_acc++;
        pop = ev && rsp_ready;
        if (pop) begin
            last_id  = rsp_id;
            last_res = rsp_result;
        end
        if (g >= 0) begin
            ga = req_a[g*32 +: 32];
            gb = req_b[g*32 +: 32];
            q.push_back('{id: g, res: ga * gb, issue: cyc});
            exp_mul_a = ga;
            exp_mul_b = gb;
            m_ptr = (g + 1) % 4;
            m_out++;
        end else begin
            exp_mul_a = '0;
            exp_mul_b = '0;
        end
        if (pop) begin
            void'(q.pop_front());
            last_pop = cyc;
            m_out--;
        end
        @(posedge clk2);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            @(negedge clk2);
            check("req_ready_in_reset", 64'(req_ready), 64'd0);
            @(posedge clk2);
            #1;
            cyc++;
        end
        reset = 1'b0;
        q.delete();
        m_out = 0;
        m_ptr = 0;
        exp_mul_a = '0;
        exp_mul_b = '0;
        last_pop = -100;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        @(posedge clk2);
        #1;
        do_reset(2);

        // Reset state
        @(negedge clk2);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mul_a", 64'(mul_a), 64'd0);
        @(posedge clk2);
        #1;
        cyc++;

        // Single op: requester 2, 7*6
        rsp_ready = 1'b1;
        set_op(2, 32'd7, 32'd6);
        req_valid = 4'b0100;
        cycle();
        req_valid = 4'b0000;
        repeat (8) cycle();
        check("single_id", 64'(last_id), 64'd2);
        check("single_result", 64'(last_res), 64'd42);

        // All four valid together from ptr 0
        do_reset(1);
        for (int i = 0; i < 4; i++) set_op(i, 32'(i + 1), 32'(10 * i + 3));
        req_valid = 4'b1111;
        repeat (4) cycle();
        req_valid = 4'b0000;
        repeat (10) cycle();
        check("rr_last_id", 64'(last_id), 64'd3);

        // Credit exhaustion with the consumer stalled
        do_reset(1);
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        acc_base = obs_acc;
        repeat (14) cycle();
        check("accepts_at_full", 64'(obs_acc - acc_base), 64'd8);
        acc_base = obs_acc;
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        repeat (3) cycle();
        check("accepts_after_one_pop", 64'(obs_acc - acc_base), 64'd1);

        // Steady state: issue and pop every cycle at full credits
        rsp_ready = 1'b1;
        repeat (20) cycle();
        req_valid = 4'b0000;
        repeat (15) cycle();

        // Truncation of the product
        set_op(1, 32'hFFFF_FFFF, 32'd2);
        req_valid = 4'b0010;
        cycle();
        req_valid = 4'b0000;
        repeat (8) cycle();
        check("trunc_ffff", 64'(last_res), 64'hFFFF_FFFE);
        set_op(3, 32'h0001_0000, 32'h0001_0000);
        req_valid = 4'b1000;
        cycle();
        req_valid = 4'b0000;
        repeat (8) cycle();
        check("trunc_wrap", 64'(last_res), 64'd0);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) set_op(i, $urandom, $urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        repeat (20) cycle();

        // Reset with 3 ops in flight and 2 queued
        do_reset(1);
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        repeat (5) cycle();
        req_valid = 4'b0000;
        do_reset(1);
        @(negedge clk2);
        check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_mul_a", 64'(mul_a), 64'd0);
        @(posedge clk2);
        #1;
        cyc++;
        rsp_ready = 1'b1;
        repeat (8) cycle();
        set_op(0, 32'd3, 32'd5);
        req_valid = 4'b0001;
        cycle();
        req_valid = 4'b0000;
        repeat (8) cycle();
        check("post_rst_id", 64'(last_id), 64'd0);
        check("post_rst_result", 64'(last_res), 64'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
